// File: rtl/dbus_arbiter.sv
// dbus_arbiter: round-robin owner of the single data-memory port, shared by M0 (core) and M1 (debug/loader).
// Optional forced release of a held lock is enabled by defining DBUS_ARB_LOCK_TIMEOUT_EN.

module dbus_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_m0_req,
   input  logic              i_m0_we,
   input  logic              i_m0_lock,
   input  logic [AW-1:0]     i_m0_addr,
   input  logic [DW-1:0]     i_m0_wdata,
   input  logic [(DW/8)-1:0] i_m0_wmask,
   output logic              o_m0_gnt,
   output logic              o_m0_rvalid,
   output logic [DW-1:0]     o_m0_rdata,
   input  logic              i_m1_req,
   input  logic              i_m1_we,
   input  logic              i_m1_lock,
   input  logic [AW-1:0]     i_m1_addr,
   input  logic [DW-1:0]     i_m1_wdata,
   input  logic [(DW/8)-1:0] i_m1_wmask,
   output logic              o_m1_gnt,
   output logic              o_m1_rvalid,
   output logic [DW-1:0]     o_m1_rdata,
   output logic              o_mem_we,
   output logic [AW-1:0]     o_mem_addr,
   output logic [DW-1:0]     o_mem_wdata,
   output logic [(DW/8)-1:0] o_mem_wmask,
   input  logic [DW-1:0]     i_mem_rdata,
   output logic              o_lock_timeout
);

   localparam int MW = DW / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic          r_last;
   logic          w_last_eff;
   logic          r_m0_gnt;
   logic          r_m1_gnt;
   logic          r_m0_rvalid;
   logic          r_m1_rvalid;
   logic [DW-1:0] r_m0_rdata;
   logic [DW-1:0] r_m1_rdata;
   logic          w_acc0;
   logic          w_acc1;
   logic          w_owner_lock;
   logic          w_other_req;
   logic          w_lock_stay;
   logic          w_force;

   // Access decode: an access is a cycle where the owner is also requesting
   always_comb begin
      w_acc0       = 1'b0;
      w_acc1       = 1'b0;
      w_owner_lock = 1'b0;
      w_other_req  = 1'b0;
      case (r_state)
         ST_OWN0: begin
            w_acc0       = i_m0_req;
            w_owner_lock = i_m0_req & i_m0_lock;
            w_other_req  = i_m1_req;
         end
         ST_OWN1: begin
            w_acc1       = i_m1_req;
            w_owner_lock = i_m1_req & i_m1_lock;
            w_other_req  = i_m0_req;
         end
         default: begin
            w_acc0       = 1'b0;
            w_acc1       = 1'b0;
            w_owner_lock = 1'b0;
            w_other_req  = 1'b0;
         end
      endcase
   end

   // Memory-side mux: follows the owner, all zero while idle
   always_comb begin
      o_mem_we    = 1'b0;
      o_mem_addr  = {AW{1'b0}};
      o_mem_wdata = {DW{1'b0}};
      o_mem_wmask = {MW{1'b0}};
      case (r_state)
         ST_OWN0: begin
            o_mem_we    = i_m0_req & i_m0_we;
            o_mem_addr  = i_m0_addr;
            o_mem_wdata = i_m0_wdata;
            o_mem_wmask = i_m0_wmask;
         end
         ST_OWN1: begin
            o_mem_we    = i_m1_req & i_m1_we;
            o_mem_addr  = i_m1_addr;
            o_mem_wdata = i_m1_wdata;
            o_mem_wmask = i_m1_wmask;
         end
         default: begin
            o_mem_we    = 1'b0;
            o_mem_addr  = {AW{1'b0}};
            o_mem_wdata = {DW{1'b0}};
            o_mem_wmask = {MW{1'b0}};
         end
      endcase
   end

`ifdef DBUS_ARB_LOCK_TIMEOUT_EN
   localparam int            CW       = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] LOCK_MAX = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_lock_cnt;
   logic          r_lock_timeout;

   // Lock override once the locked run has used up its budget and the other side waits
   always_comb begin
      w_force = w_owner_lock & w_other_req & (r_lock_cnt == LOCK_MAX);
   end

   // Locked-run counter saturates so a late competing request is served at once
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_lock_cnt     <= {CW{1'b0}};
         r_lock_timeout <= 1'b0;
      end else begin
         r_lock_timeout <= w_force;
         if (w_lock_stay) begin
            if (r_lock_cnt != LOCK_MAX) begin
               r_lock_cnt <= r_lock_cnt + {{(CW-1){1'b0}}, 1'b1};
            end else begin
               r_lock_cnt <= r_lock_cnt;
            end
         end else begin
            r_lock_cnt <= {CW{1'b0}};
         end
      end
   end

   assign o_lock_timeout = r_lock_timeout;
`else
   // Lock is honoured indefinitely in this build
   always_comb begin
      w_force = 1'b0;
   end

   assign o_lock_timeout = 1'b0;
`endif

   // Next owner; `last` already reflects an access made in this same cycle
   always_comb begin
      w_next_state = ST_IDLE;
      w_lock_stay  = 1'b0;
      if (w_acc0) begin
         w_last_eff = 1'b0;
      end else if (w_acc1) begin
         w_last_eff = 1'b1;
      end else begin
         w_last_eff = r_last;
      end
      if (w_owner_lock && !w_force) begin
         w_next_state = r_state;
         w_lock_stay  = 1'b1;
      end else if (i_m0_req && i_m1_req) begin
         w_next_state = w_last_eff ? ST_OWN0 : ST_OWN1;
      end else if (i_m0_req) begin
         w_next_state = ST_OWN0;
      end else if (i_m1_req) begin
         w_next_state = ST_OWN1;
      end else begin
         w_next_state = ST_IDLE;
      end
   end

   // Ownership state, round-robin pointer and registered grants
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_last   <= 1'b1;
         r_m0_gnt <= 1'b0;
         r_m1_gnt <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_last   <= w_last_eff;
         r_m0_gnt <= (w_next_state == ST_OWN0);
         r_m1_gnt <= (w_next_state == ST_OWN1);
      end
   end

   // Read capture: data is held until the next read completes for the same master
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
         r_m0_rdata  <= {DW{1'b0}};
         r_m1_rdata  <= {DW{1'b0}};
      end else begin
         r_m0_rvalid <= w_acc0 & ~i_m0_we;
         r_m1_rvalid <= w_acc1 & ~i_m1_we;
         if (w_acc0 && !i_m0_we) begin
            r_m0_rdata <= i_mem_rdata;
         end else begin
            r_m0_rdata <= r_m0_rdata;
         end
         if (w_acc1 && !i_m1_we) begin
            r_m1_rdata <= i_mem_rdata;
         end else begin
            r_m1_rdata <= r_m1_rdata;
         end
      end
   end

   assign o_m0_gnt    = r_m0_gnt;
   assign o_m1_gnt    = r_m1_gnt;
   assign o_m0_rvalid = r_m0_rvalid;
   assign o_m1_rvalid = r_m1_rvalid;
   assign o_m0_rdata  = r_m0_rdata;
   assign o_m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
// A 16-word memory fixture sits on the memory port; the model keeps its own copy of memory contents.

module tb_dbus_arbiter;

   localparam int TB_TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req = 2'b00;
   logic [1:0]  we = 2'b00;
   logic [1:0]  lock = 2'b00;
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic [3:0]  wmask [2];

   logic        o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid;
   logic [31:0] o_m0_rdata, o_m1_rdata;
   logic        o_mem_we, o_lock_timeout;
   logic [31:0] o_mem_addr, o_mem_wdata, mem_rdata;
   logic [3:0]  o_mem_wmask;

   logic [31:0] mem_arr [16];
   logic [31:0] ref_mem [16];
   logic        mem_init = 1'b1;

   int          checks = 0;
   int          failures = 0;

   // reference model state: owner -1 idle, 0, 1
   int          own;
   int          last;
   int          lk;
   logic [31:0] exp_rdata [2];
   logic [1:0]  exp_rv;
   logic        exp_lt;

   always #5 clk = ~clk;

   dbus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TB_TO)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_m0_req(req[0]), .i_m0_we(we[0]), .i_m0_lock(lock[0]),
      .i_m0_addr(addr[0]), .i_m0_wdata(wdata[0]), .i_m0_wmask(wmask[0]),
      .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
      .i_m1_req(req[1]), .i_m1_we(we[1]), .i_m1_lock(lock[1]),
      .i_m1_addr(addr[1]), .i_m1_wdata(wdata[1]), .i_m1_wmask(wmask[1]),
      .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
      .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .o_mem_wmask(o_mem_wmask), .i_mem_rdata(mem_rdata), .o_lock_timeout(o_lock_timeout)
   );

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] init_word(input int i);
      return 32'h1000_0000 + 32'(i) * 32'h0011_0101;
   endfunction

   assign mem_rdata = mem_arr[o_mem_addr[5:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem_arr[i] <= init_word(i);
      end else if (o_mem_we) begin
         mem_arr[o_mem_addr[5:2]] <= merge(mem_arr[o_mem_addr[5:2]], o_mem_wdata, o_mem_wmask);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      own = -1;
      last = 1;
      lk = 0;
      exp_rdata[0] = 32'd0;
      exp_rdata[1] = 32'd0;
      exp_rv = 2'b00;
      exp_lt = 1'b0;
   endtask

   task automatic clear_inputs();
      req = 2'b00; we = 2'b00; lock = 2'b00;
      for (int j = 0; j < 2; j++) begin
         addr[j] = 32'd0; wdata[j] = 32'd0; wmask[j] = 4'd0;
      end
   endtask

   // one clock: check memory-side outputs, advance the model, check registered outputs
   task automatic step();
      logic        acc, lstay, frc, ewe;
      logic [1:0]  nrv;
      logic [31:0] ea, ed;
      logic [3:0]  em;
      int          nown, l;
      #2;
      acc = (own >= 0) && req[own];
      if (own >= 0) begin
         ea = addr[own]; ed = wdata[own]; em = wmask[own]; ewe = req[own] & we[own];
      end else begin
         ea = 32'd0; ed = 32'd0; em = 4'd0; ewe = 1'b0;
      end
      chk("mem_we", 32'(o_mem_we), 32'(ewe));
      chk("mem_addr", o_mem_addr, ea);
      chk("mem_wdata", o_mem_wdata, ed);
      chk("mem_wmask", 32'(o_mem_wmask), 32'(em));
      nrv = 2'b00;
      if (acc) begin
         if (we[own]) ref_mem[addr[own][5:2]] = merge(ref_mem[addr[own][5:2]], wdata[own], wmask[own]);
         else begin
            exp_rdata[own] = ref_mem[addr[own][5:2]];
            nrv[own] = 1'b1;
         end
      end
      lstay = (own >= 0) && req[own] && lock[own];
      frc = 1'b0;
`ifdef DBUS_ARB_LOCK_TIMEOUT_EN
      frc = lstay && req[1-own] && (lk == TB_TO - 1);
`endif
      l = acc ? own : last;
      if (lstay && !frc) nown = own;
      else if (req == 2'b11) nown = 1 - l;
      else if (req[0]) nown = 0;
      else if (req[1]) nown = 1;
      else nown = -1;
      if (lstay && !frc) lk = (lk == TB_TO - 1) ? lk : lk + 1;
      else lk = 0;
      last = l;
      @(posedge clk);
      #1;
      own = nown;
      exp_rv = nrv;
`ifdef DBUS_ARB_LOCK_TIMEOUT_EN
      exp_lt = frc;
`else
      exp_lt = 1'b0;
`endif
      chk("gnt0", 32'(o_m0_gnt), 32'(own == 0));
      chk("gnt1", 32'(o_m1_gnt), 32'(own == 1));
      chk("rvalid0", 32'(o_m0_rvalid), 32'(exp_rv[0]));
      chk("rvalid1", 32'(o_m1_rvalid), 32'(exp_rv[1]));
      chk("rdata0", o_m0_rdata, exp_rdata[0]);
      chk("rdata1", o_m1_rdata, exp_rdata[1]);
      chk("lock_timeout", 32'(o_lock_timeout), 32'(exp_lt));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_gnt0", 32'(o_m0_gnt), 32'd0);
      chk("rst_gnt1", 32'(o_m1_gnt), 32'd0);
      chk("rst_rvalid", {30'd0, o_m1_rvalid, o_m0_rvalid}, 32'd0);
      chk("rst_rdata0", o_m0_rdata, 32'd0);
      chk("rst_rdata1", o_m1_rdata, 32'd0);
      chk("rst_mem_we", 32'(o_mem_we), 32'd0);
      chk("rst_mem_addr", o_mem_addr, 32'd0);
      chk("rst_lock_timeout", 32'(o_lock_timeout), 32'd0);
      rst = 1'b0;
   endtask

   // full-word write through M1 from idle, as the loader would do
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = a; wdata[1] = d; wmask[1] = 4'hF;
      step();
      step();
      req[1] = 1'b0; we[1] = 1'b0;
      step();
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      clear_inputs();
      do_reset();
      mem_init = 1'b0;

      // single read with two-cycle latency
      bus_write(32'h10, 32'hDEADBEEF);
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
      step();
      chk("t1_gnt", 32'(o_m0_gnt), 32'd1);
      step();
      chk("t1_rvalid", 32'(o_m0_rvalid), 32'd1);
      chk("t1_rdata", o_m0_rdata, 32'hDEADBEEF);
      req[0] = 1'b0;
      step();

      // contention from reset alternates 0,1,0,1
      do_reset();
      req = 2'b11; we = 2'b00;
      for (int k = 0; k < 5; k++) begin
         addr[0] = 32'(k * 8);
         addr[1] = 32'(k * 8 + 4);
         step();
         if (k < 4) chk("t2_order", 32'(o_m0_gnt), 32'((k % 2) == 0));
      end
      req = 2'b00;
      step();
      step();

      // partial byte write then read-back
      bus_write(32'h20, 32'hAABBCCDD);
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h11223344; wmask[1] = 4'b0010;
      step();
      step();
      we[1] = 1'b0;
      step();
      chk("t3_rvalid", 32'(o_m1_rvalid), 32'd1);
      chk("t3_rdata", o_m1_rdata, 32'hAABB33DD);
      req[1] = 1'b0;
      step();

`ifndef DBUS_ARB_LOCK_TIMEOUT_EN
      // locked burst of 8 writes holds off M0
      req[1] = 1'b1; we[1] = 1'b1; lock[1] = 1'b1; addr[1] = 32'h30; wmask[1] = 4'hF;
      step();
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0;
      for (int k = 0; k < 8; k++) begin
         addr[1] = 32'(32'h20 + 4 * k);
         wdata[1] = $urandom;
         lock[1] = (k != 7);
         step();
         if (k < 7) chk("t4_hold", 32'(o_m0_gnt), 32'd0);
         else chk("t4_handoff", 32'(o_m0_gnt), 32'd1);
      end
`else
      // lock overridden after TIMEOUT locked cycles
      req[0] = 1'b1; we[0] = 1'b1; lock[0] = 1'b1; addr[0] = 32'h0; wdata[0] = 32'h5; wmask[0] = 4'hF;
      step();
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h4;
      for (int k = 0; k < 4; k++) begin
         step();
         if (k < 3) chk("t6_hold", 32'(o_m1_gnt), 32'd0);
         else begin
            chk("t6_force", 32'(o_m1_gnt), 32'd1);
            chk("t6_pulse", 32'(o_lock_timeout), 32'd1);
         end
      end
      step();
      chk("t6_pulse_end", 32'(o_lock_timeout), 32'd0);
`endif
      clear_inputs();
      step();
      step();

      // reset asserted during a read access: no rvalid
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("t5_gnt_async", 32'(o_m0_gnt), 32'd0);
      chk("t5_mem_we", 32'(o_mem_we), 32'd0);
      @(posedge clk);
      #1;
      chk("t5_rvalid", 32'(o_m0_rvalid), 32'd0);
      rst = 1'b0;
      model_reset();
      // reset asserted during a write access: memory untouched
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h3C; wdata[0] = 32'hCAFEF00D; wmask[0] = 4'hF;
      step();
      #2;
      rst = 1'b1;
      #1;
      chk("t5w_mem_we", 32'(o_mem_we), 32'd0);
      @(posedge clk);
      #1;
      chk("t5w_nowrite", mem_arr[15], ref_mem[15]);
      rst = 1'b0;
      clear_inputs();
      model_reset();
      step();

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         req = 2'($urandom_range(0, 3));
         we = 2'($urandom_range(0, 3));
         lock = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         for (int j = 0; j < 2; j++) begin
            addr[j] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            wdata[j] = $urandom;
            wmask[j] = 4'($urandom_range(0, 15));
         end
         step();
      end
      clear_inputs();
      step();
      step();
      for (int i = 0; i < 16; i++) chk("mem_final", mem_arr[i], ref_mem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
